// File: rtl/rs_sel_pkg.sv
// rs_sel_pkg: shared defaults and snapshot entry type for the RS select FIFO
package rs_sel_pkg;
  localparam int RS_BUF_COUNT = 32;
  localparam int RS_GROUP     = 8;
  localparam int RS_DEPTH     = 4;
  typedef logic [RS_BUF_COUNT-1:0] snap_t;
endpackage

// File: rtl/bit_find_first_bit.sv
// bit_find_first_bit: isolates the lowest set bit of a vector (zero in, zero out)
//   i_vec   : input vector
//   o_first : one-hot lowest set bit of i_vec, or 0
module bit_find_first_bit #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_vec,
  output logic [W-1:0] o_first
);
  assign o_first = i_vec & (~i_vec + W'(1));
endmodule

// File: rtl/rs_sel_snap_fifo.sv
// rs_sel_snap_fifo: snapshot FIFO with head update, merge-on-full and flush
//   clk, rst (async active-low), i_flush (sync clear)
//   i_push/i_push_data : append a snapshot (ORed into tail when full without pop)
//   i_pop              : drop the head
//   i_upd/i_upd_data   : overwrite the head in place
//   o_head, o_count    : head entry and occupancy
//   o_merge            : one-cycle pulse after a merge into the tail
module rs_sel_snap_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_data,
  input  logic          i_pop,
  input  logic          i_upd,
  input  logic [W-1:0]  i_upd_data,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_merge
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [W-1:0]  w_nxt [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_wr_idx;
  logic          r_merge;
  logic          w_merge;
  assign w_merge  = i_push & (r_count == CW'(DEPTH)) & ~i_pop;
  assign w_wr_idx = r_count - CW'(i_pop);
  assign o_head   = r_mem[0];
  assign o_count  = r_count;
  assign o_merge  = r_merge;
  // entry 0 is the head; a pop shifts everything down one slot
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) w_nxt[i] = i_pop ? r_mem[i+1] : r_mem[i];
    w_nxt[DEPTH-1] = i_pop ? '0 : r_mem[DEPTH-1];
    if (i_upd) w_nxt[0] = i_upd_data;
    for (int i = 0; i < DEPTH; i++)
      if (i_push && !w_merge && w_wr_idx == CW'(i)) w_nxt[i] = i_push_data;
    if (w_merge) w_nxt[DEPTH-1] = r_mem[DEPTH-1] | i_push_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem   <= '{default: '0};
      r_count <= '0;
      r_merge <= 1'b0;
    end else if (i_flush) begin
      r_mem   <= '{default: '0};
      r_count <= '0;
      r_merge <= 1'b0;
    end else begin
      r_mem   <= w_nxt;
      r_count <= r_count + CW'(i_push & ~w_merge) - CW'(i_pop);
      r_merge <= w_merge;
    end
  end
endmodule

// File: rtl/rs_select_fifo_gen.sv
// rs_select_fifo_gen: reservation-station select with ready-snapshot FIFO
//   clk, rst (async active-low), except (sync flush)
//   portReady : live ready vector      portEn     : issue port accepts a pick
//   rsSelect  : one-hot pick or 0      found      : pick valid (DEF_FOUND when idle)
//   found_no_z: found gated by portEn  fifoCount  : occupied snapshots
//   mergeEvt  : pulse after a push merged into a full FIFO
//   rsGroup   : one-hot group of rsSelect, only when RS_SEL_GROUP_EN is defined
module rs_select_fifo_gen
  import rs_sel_pkg::*;
#(
  parameter int   BUF_COUNT = RS_BUF_COUNT,
  parameter int   GROUP     = RS_GROUP,
  parameter int   DEPTH     = RS_DEPTH,
  parameter logic DEF_FOUND = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         except,
  input  logic [BUF_COUNT-1:0]         portReady,
  input  logic                         portEn,
  output logic [BUF_COUNT-1:0]         rsSelect,
  output logic                         found,
  output logic                         found_no_z,
  output logic [$clog2(DEPTH+1)-1:0]   fifoCount,
  output logic                         mergeEvt
`ifdef RS_SEL_GROUP_EN
  ,
  output logic [BUF_COUNT/GROUP-1:0]   rsGroup
`endif
);
  logic [BUF_COUNT-1:0] r_mask;
  logic [BUF_COUNT-1:0] w_ready_m;
  logic [BUF_COUNT-1:0] w_head;
  logic [BUF_COUNT-1:0] w_live;
  logic [BUF_COUNT-1:0] w_src;
  logic [BUF_COUNT-1:0] w_src_first;
  logic [BUF_COUNT-1:0] w_head_first;
  logic [BUF_COUNT-1:0] w_consumed;
  logic [BUF_COUNT-1:0] w_push_data;
  logic                 w_empty;
  logic                 w_take;
  logic                 w_single;
  if (BUF_COUNT % GROUP != 0) begin : g_bad_group
    $error("BUF_COUNT must be a multiple of GROUP");
  end
  assign w_ready_m   = portReady & r_mask;
  assign w_empty     = fifoCount == '0;
  assign w_live      = w_head & portReady;
  assign w_src       = w_empty ? w_ready_m : w_live;
  assign rsSelect    = portEn ? w_src_first : '0;
  assign found       = portEn ? |w_src : DEF_FOUND;
  assign found_no_z  = portEn & |w_src;
  assign w_take      = portEn & ~w_empty;
  // a head whose bits have all gone unready still retires one bit per accept
  assign w_consumed  = !w_take ? '0 : (|w_live ? w_src_first : w_head_first);
  assign w_single    = (w_head & (w_head - BUF_COUNT'(1))) == '0;
  assign w_push_data = w_empty ? (w_ready_m & ~rsSelect) : w_ready_m;
  bit_find_first_bit #(.W(BUF_COUNT)) u_ffb_src (.i_vec(w_src), .o_first(w_src_first));
  bit_find_first_bit #(.W(BUF_COUNT)) u_ffb_head (.i_vec(w_head), .o_first(w_head_first));
  rs_sel_snap_fifo #(.W(BUF_COUNT), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (except),
    .i_push      (|w_push_data),
    .i_push_data (w_push_data),
    .i_pop       (w_take & w_single),
    .i_upd       (w_take & ~w_single),
    .i_upd_data  (w_head & ~w_consumed),
    .o_head      (w_head),
    .o_count     (fifoCount),
    .o_merge     (mergeEvt)
  );
  // bits captured into a snapshot leave the mask; the picked/consumed bit returns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_mask <= '1;
    else if (except) r_mask <= '1;
    else r_mask <= (r_mask & ~w_ready_m) | (w_empty ? rsSelect : w_consumed);
  end
`ifdef RS_SEL_GROUP_EN
  for (genvar g = 0; g < BUF_COUNT / GROUP; g++) begin : g_grp
    assign rsGroup[g] = |rsSelect[g*GROUP +: GROUP];
  end
`endif
endmodule

// File: tb/tb_rs_select_fifo_gen.sv
// tb_rs_select_fifo_gen: table-driven scoreboard bench for rs_select_fifo_gen
module tb_rs_select_fifo_gen;
  import rs_sel_pkg::*;
  typedef struct {
    logic       exc;
    logic       en;
    snap_t      rdy;
    snap_t      sel;
    logic       found;
    logic       fnz;
    logic [2:0] cnt;
    snap_t      mask;
    logic       merge;
    snap_t      tail;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       except = 1'b0;
  logic       portEn = 1'b0;
  snap_t      portReady = '0;
  snap_t      rsSelect;
  logic       found;
  logic       found_no_z;
  logic [2:0] fifoCount;
  logic       mergeEvt;
`ifdef RS_SEL_GROUP_EN
  logic [3:0] rsGroup;
`endif
  int n_chk = 0;
  int n_pass = 0;
  vec_t tbl[$];
  vec_t sb[$];
  rs_select_fifo_gen #(.BUF_COUNT(32), .GROUP(8), .DEPTH(4), .DEF_FOUND(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .except     (except),
    .portReady  (portReady),
    .portEn     (portEn),
    .rsSelect   (rsSelect),
    .found      (found),
    .found_no_z (found_no_z),
    .fifoCount  (fifoCount),
    .mergeEvt   (mergeEvt)
`ifdef RS_SEL_GROUP_EN
    ,
    .rsGroup    (rsGroup)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
`ifdef RS_SEL_GROUP_EN
  function automatic logic [3:0] grp(input snap_t s);
    logic [3:0] g;
    for (int k = 0; k < 4; k++) g[k] = |s[k*8 +: 8];
    return g;
  endfunction
`endif
  task automatic step(input vec_t v);
    vec_t cur;
    except = v.exc;
    portEn = v.en;
    portReady = v.rdy;
    sb.push_back(v);
    @(negedge clk);
    cur = sb.pop_front();
    chk("rsSelect", rsSelect, cur.sel);
    chk("found", 32'(found), 32'(cur.found));
    chk("found_no_z", 32'(found_no_z), 32'(cur.fnz));
`ifdef RS_SEL_GROUP_EN
    chk("rsGroup", 32'(rsGroup), 32'(grp(cur.sel)));
`endif
    @(posedge clk);
    #1;
    chk("fifoCount", 32'(fifoCount), 32'(cur.cnt));
    chk("mask", dut.r_mask, cur.mask);
    chk("mergeEvt", 32'(mergeEvt), 32'(cur.merge));
    if (cur.tail != '0) chk("tail", dut.u_fifo.r_mem[3], cur.tail);
    except = 1'b0;
  endtask
  initial begin
    tbl.push_back('{1'b0, 1'b1, 32'h6, 32'h2, 1'b1, 1'b1, 3'd1, 32'hFFFF_FFFB, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h4, 32'h4, 1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'hF, 32'h0, 1'b1, 1'b0, 3'd1, 32'hFFFF_FFF0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'hC, 32'h4, 1'b1, 1'b1, 3'd1, 32'hFFFF_FFF4, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 3'd1, 32'hFFFF_FFF5, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd1, 32'hFFFF_FFF5, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 32'h3, 32'h2, 1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 3'd1, 32'hFFFF_FFCF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h20, 32'h20, 1'b1, 1'b1, 3'd1, 32'hFFFF_FFEF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h1, 32'h0, 1'b1, 1'b0, 3'd1, 32'hFFFF_FFFE, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h2, 32'h0, 1'b1, 1'b0, 3'd2, 32'hFFFF_FFFC, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 3'd3, 32'hFFFF_FFF8, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 3'd4, 32'hFFFF_FFF0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 3'd4, 32'hFFFF_FEF0, 1'b1, 32'h108});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd4, 32'hFFFF_FEF0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h1, 32'h1, 1'b1, 1'b1, 3'd3, 32'hFFFF_FEF1, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 32'h1000, 32'h0, 1'b0, 1'b0, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h1000, 32'h1000, 1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'h0});
    portEn = 1'b1;
    portReady = 32'h5;
    repeat (2) @(negedge clk);
    chk("rst_sel", rsSelect, 32'h1);
    chk("rst_found", 32'(found), 32'h1);
    chk("rst_count", 32'(fifoCount), 32'h0);
    chk("rst_mask", dut.r_mask, 32'hFFFF_FFFF);
    chk("rst_merge", 32'(mergeEvt), 32'h0);
    chk("rst_entry", dut.u_fifo.r_mem[0], 32'h0);
    portReady = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    step('{1'b0, 1'b0, 32'h1, 32'h0, 1'b1, 1'b0, 3'd1, 32'hFFFF_FFFE, 1'b0, 32'h0});
    step('{1'b0, 1'b0, 32'h2, 32'h0, 1'b1, 1'b0, 3'd2, 32'hFFFF_FFFC, 1'b0, 32'h0});
    step('{1'b0, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 3'd3, 32'hFFFF_FFF8, 1'b0, 32'h0});
    step('{1'b0, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 3'd4, 32'hFFFF_FFF0, 1'b0, 32'h0});
    step('{1'b0, 1'b1, 32'h101, 32'h1, 1'b1, 1'b1, 3'd4, 32'hFFFF_FEF1, 1'b0, 32'h100});
    chk("full_pp_head", dut.u_fifo.r_mem[0], 32'h2);
    rst = 1'b0;
    portEn = 1'b1;
    portReady = 32'h6;
    #1;
    chk("midrst_count", 32'(fifoCount), 32'h0);
    chk("midrst_mask", dut.r_mask, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("midrst_sel", rsSelect, 32'h2);
    chk("midrst_found", 32'(found), 32'h1);
    @(posedge clk);
    #1;
    chk("midrst_hold", 32'(fifoCount), 32'h0);
    portReady = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step('{1'b0, 1'b1, 32'h80, 32'h80, 1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'h0});
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rs_select_fifo_gen.md
RS_SELECT_FIFO_GEN -- requirements
Module: rs_select_fifo_gen

Interface
REQ-001 SHALL have parameter BUF_COUNT, default 32: reservation-station entries; legal values are multiples of GROUP, 8..128.
REQ-002 SHALL have parameter GROUP, default 8: entries per group for the group-select output.
REQ-003 SHALL have parameter DEPTH, default 4: snapshot FIFO depth; legal values 2..8.
REQ-004 SHALL have parameter DEF_FOUND, default 1'b1: value of found when portEn=0.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port except, input, 1 bit: synchronous pipeline flush.
REQ-008 SHALL have port portReady, input, BUF_COUNT bits: live ready vector.
REQ-009 SHALL have port portEn, input, 1 bit: the issue port accepts a selection this cycle.
REQ-010 SHALL have port rsSelect, output, BUF_COUNT bits: one-hot or zero selected entry.
REQ-011 SHALL have port found, output, 1 bit: a selection is valid.
REQ-012 SHALL have port found_no_z, output, 1 bit: as found, but 0 when portEn=0.
REQ-013 SHALL have port rsGroup, output, BUF_COUNT/GROUP bits: one-hot group of rsSelect (present only with the macro).
REQ-014 SHALL have port fifoCount, output, $clog2(DEPTH+1) bits: occupied snapshots.
REQ-015 SHALL have port mergeEvt, output, 1 bit: pulses when a push merges into a full FIFO.

Function
REQ-016 SHALL hold mask[BUF_COUNT]; define readyM = portReady & mask.
REQ-017 SHALL, when FIFO empty: rsSelect = portEn ? lowest set bit of readyM : 0; found = portEn ? |readyM : DEF_FOUND.
REQ-018 SHALL, when FIFO empty, push readyM & ~rsSelect if that value is nonzero (this covers portEn=0 with readyM!=0).
REQ-019 SHALL, when FIFO nonempty with head H: live = H & portReady; rsSelect = portEn ? lowest bit of live : 0; found = portEn ? |live : DEF_FOUND.
REQ-020 SHALL, when FIFO nonempty, define consumed = lowest bit of live if live!=0, else lowest bit of H; consumed is 0 when portEn=0.
REQ-021 SHALL, on portEn with FIFO nonempty: if H has >1 bit set, H <= H & ~consumed; else pop the head.
REQ-022 SHALL, when FIFO nonempty, push readyM when it is nonzero; push and pop in the same cycle SHALL both take effect, with count unchanged.
REQ-023 SHALL, on a push when count==DEPTH and there is no pop: OR the data into the tail entry, leave count unchanged, and assert mergeEvt for one cycle.
REQ-024 SHALL set mask <= (mask & ~readyM) | consumed_or_select every cycle, where consumed_or_select is rsSelect when the FIFO is empty and consumed otherwise.
REQ-025 SHALL compute outputs combinationally from state and inputs, with zero-cycle select latency; an entry pushed in cycle N is selectable from head no earlier than N+1.
REQ-026 SHALL make except clear the FIFO (count=0, entries 0) and set mask to all-ones at the next edge; except has priority over push and pop.

Reset
REQ-027 SHALL, while rst=0: count=0, all entries=0, mask=all-ones, mergeEvt=0; rsSelect and found follow the empty-FIFO rules.
REQ-028 SHALL behave as after reset when rst is asserted mid-operation, with no residual selection in the following cycle.

Configuration
REQ-029 SHALL, with RS_SEL_GROUP_EN defined, provide rsGroup = OR-reduction per GROUP slice of rsSelect; without it, SHALL omit the rsGroup port and its logic.

Structure
REQ-030 SHALL place the default BUF_COUNT/GROUP/DEPTH constants and the snapshot entry typedef in the shared package rs_sel_pkg.
REQ-031 SHALL implement the FIFO as a sub-module rs_sel_snap_fifo providing push, pop, head-update, merge and flush, and SHALL reuse bit_find_first_bit for priority selection.

Verification (BUF_COUNT=32, DEPTH=4)
REQ-032 SHALL cover: after reset, portReady=0x0000_0006, portEn=1 -> rsSelect=0x2, found=1, push 0x4; next cycle rsSelect=0x4 and FIFO empty after.
REQ-033 SHALL cover: portEn=0, portReady=0x0F -> found=DEF_FOUND, found_no_z=0, rsSelect=0, count=1, mask=0xFFFF_FFF0.
REQ-034 SHALL cover: head 0x30 with portReady=0x20 -> rsSelect=0x20; then portReady=0 -> found=0, head bit 0x10 consumed and popped.
REQ-035 SHALL cover: fill 4 snapshots, then push 0x100 with no pop -> mergeEvt=1, count=4, tail entry OR 0x100.
REQ-036 SHALL cover: except asserted with count=3 -> next cycle count=0, mask=all-ones, selection from portReady directly.
REQ-037 SHALL cover, with RS_SEL_GROUP_EN: rsSelect=0x0001_0000 -> rsGroup=4'b0100; without the macro, the bench SHALL compile with no rsGroup port.
